// File: rtl/vmem_rect_fill_pkg.sv
// Shared definitions for the rectangle-fill engine.
// Contents: register offsets (addr_i[3:2]), CTRL bit indices, default screen
// geometry and the fill FSM state encoding.
package vmem_rect_fill_pkg;

  // Register select values (byte offset bits [3:2])
  localparam logic [1:0] REG_POS   = 2'd0;
  localparam logic [1:0] REG_SIZE  = 2'd1;
  localparam logic [1:0] REG_COLOR = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_IRQ_EN   = 3;

  // CTRL read bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_IRQ_EN   = 3;

  // Default geometry
  localparam int SCR_W_DEF   = 240;
  localparam int SCR_H_DEF   = 240;
  localparam int VADDR_W_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vmem_rect_walker.sv
// Raster x/y walker for the rectangle-fill engine.
// load  : latch start corner and clipped extents (ew, eh >= 1 guaranteed).
// step  : advance one pixel in raster order.
// cx/cy : current pixel coordinate; last: current pixel is the final one.
module vmem_rect_walker (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] ew,
  input  logic [8:0] eh,
  output logic [7:0] cx,
  output logic [7:0] cy,
  output logic       last
);

  logic [7:0] cx_reg, cy_reg, xs_reg;
  logic [8:0] x_last_reg, y_last_reg;
  logic [8:0] x_last_next, y_last_next;
  logic       row_end;

  // 9-bit sums: x0 + ew tops out at the screen width and never wraps.
  assign x_last_next = {1'b0, x0} + ew - 9'd1;
  assign y_last_next = {1'b0, y0} + eh - 9'd1;

  assign row_end = ({1'b0, cx_reg} == x_last_reg);
  assign last    = row_end && ({1'b0, cy_reg} == y_last_reg);
  assign cx      = cx_reg;
  assign cy      = cy_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cx_reg     <= '0;
      cy_reg     <= '0;
      xs_reg     <= '0;
      x_last_reg <= '0;
      y_last_reg <= '0;
    end else if (load) begin
      cx_reg     <= x0;
      cy_reg     <= y0;
      xs_reg     <= x0;
      x_last_reg <= x_last_next;
      y_last_reg <= y_last_next;
    end else if (step) begin
      if (row_end) begin
        cx_reg <= xs_reg;
        cy_reg <= cy_reg + 8'd1;
      end else begin
        cx_reg <= cx_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vmem_rect_fill.sv
// Memory-mapped rectangle-fill engine feeding the video memory write port.
// The CPU programs POS/SIZE/COLOR, then writes CTRL.START; one pixel is
// written per unstalled cycle in raster order, clipped to the screen.
// Ports: clk_i/rst_ni (sync, active-low); we_i/addr_i/wdata_i register
// writes; rdata_o registered read (1-cycle latency); vmem_stall_i CPU owns
// vmem; vmem_we_o/vmem_addr_o/vmem_wdata_o pixel write; irq_o completion.
// Optional build macro: VMEM_RECT_FILL_IRQ_EN (irq_o = done & irq_en);
// when undefined irq_o is 0 and CTRL bit3 reads 0.
module vmem_rect_fill
  import vmem_rect_fill_pkg::*;
#(
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF,
  parameter int VADDR_W = VADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  input  logic               vmem_stall_i,
  output logic               vmem_we_o,
  output logic [VADDR_W-1:0] vmem_addr_o,
  output logic [7:0]         vmem_wdata_o,
  output logic               irq_o
);

  logic [7:0]  x0_reg, y0_reg, color_reg, col_reg;
  logic [8:0]  w_reg, h_reg;
  logic        done_reg, done_next;
  logic        irq_en_q;
  logic [31:0] rdata_reg, rdata_next;
  fill_state_e state_reg, state_next;

  logic [3:0]  reg_sel;
  logic        ctrl_wr, start_cmd, abort_cmd, clr_cmd;
  logic [8:0]  room_x, room_y, ew, eh;
  logic        empty, load, step, last;
  logic [7:0]  cx, cy;
  logic        unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      assign reg_sel[gi] = (addr_i[3:2] == 2'(gi));
    end
  endgenerate

  assign ctrl_wr   = we_i & reg_sel[REG_CTRL];
  // ABORT dominates START in the same write.
  assign start_cmd = ctrl_wr & wdata_i[CTRL_START] & ~wdata_i[CTRL_ABORT];
  assign abort_cmd = ctrl_wr & wdata_i[CTRL_ABORT];
  assign clr_cmd   = ctrl_wr & wdata_i[CTRL_CLR_DONE];

  // Clip extents to the screen; room_* is only meaningful when not empty.
  assign room_x = 9'(SCR_W) - {1'b0, x0_reg};
  assign room_y = 9'(SCR_H) - {1'b0, y0_reg};
  assign ew     = (w_reg < room_x) ? w_reg : room_x;
  assign eh     = (h_reg < room_y) ? h_reg : room_y;
  assign empty  = ({1'b0, x0_reg} >= 9'(SCR_W)) | ({1'b0, y0_reg} >= 9'(SCR_H)) |
                  (w_reg == 9'd0) | (h_reg == 9'd0);

  assign step = (state_reg == ST_RUN) & ~vmem_stall_i;

  vmem_rect_walker u_walker (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (load),
    .step   (step),
    .x0     (x0_reg),
    .y0     (y0_reg),
    .ew     (ew),
    .eh     (eh),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

  always_comb begin
    state_next = state_reg;
    done_next  = done_reg;
    load       = 1'b0;
    // Clear first so a completion in the same cycle wins.
    if (clr_cmd) done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_cmd) begin
          if (empty) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_RUN;
            load       = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_cmd) begin
          state_next = ST_IDLE;
        end else if (step && last) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef VMEM_RECT_FILL_IRQ_EN
  logic irq_en_reg;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      irq_en_reg <= 1'b0;
    else if (ctrl_wr) irq_en_reg <= wdata_i[CTRL_IRQ_EN];
  end
  assign irq_en_q = irq_en_reg;
  assign irq_o    = done_reg & irq_en_reg;
`else
  assign irq_en_q = 1'b0;
  assign irq_o    = 1'b0;
`endif

  always_comb begin
    rdata_next = '0;
    case (addr_i[3:2])
      REG_POS:   rdata_next = {16'd0, y0_reg, x0_reg};
      REG_SIZE:  rdata_next = {7'd0, h_reg, 7'd0, w_reg};
      REG_COLOR: rdata_next = {24'd0, color_reg};
      default: begin
        rdata_next[STAT_BUSY]   = (state_reg == ST_RUN);
        rdata_next[STAT_DONE]   = done_reg;
        rdata_next[STAT_IRQ_EN] = irq_en_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      color_reg <= '0;
      col_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      rdata_reg <= rdata_next;
      if (load) col_reg <= color_reg;
      if (we_i && reg_sel[REG_POS]) begin
        x0_reg <= wdata_i[7:0];
        y0_reg <= wdata_i[15:8];
      end
      if (we_i && reg_sel[REG_SIZE]) begin
        w_reg <= wdata_i[8:0];
        h_reg <= wdata_i[24:16];
      end
      if (we_i && reg_sel[REG_COLOR]) color_reg <= wdata_i[7:0];
    end
  end

  assign rdata_o      = rdata_reg;
  assign vmem_we_o    = step;
  assign vmem_addr_o  = (state_reg == ST_RUN) ? VADDR_W'({cy, cx}) : '0;
  assign vmem_wdata_o = (state_reg == ST_RUN) ? col_reg : 8'd0;

  assign unused_bits = ^{wdata_i[31:25], addr_i[1:0]};

endmodule

// File: tb/tb_vmem_rect_fill.sv
module tb_vmem_rect_fill;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        vmem_stall_i;
  logic        vmem_we_o;
  logic [15:0] vmem_addr_o;
  logic [7:0]  vmem_wdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap_addr[$];
  logic [7:0]  cap_data[$];
  int          cap_idx[$];

`ifdef VMEM_RECT_FILL_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  vmem_rect_fill dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .vmem_stall_i (vmem_stall_i),
    .vmem_we_o    (vmem_we_o),
    .vmem_addr_o  (vmem_addr_o),
    .vmem_wdata_o (vmem_wdata_o),
    .irq_o        (irq_o)
  );

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    @(posedge clk_i); #1;
    we_i    = 1'b0;
    wdata_i = '0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr_i = a;
    @(posedge clk_i); #1;
    d = rdata_o;
    $display("read  addr=%h data=%h", a, d);
  endtask

  // Observe n cycles, starting with the current one; stall per mask bit.
  task automatic capture(input int n, input logic [31:0] stall_mask);
    cap_addr.delete(); cap_data.delete(); cap_idx.delete();
    for (int i = 0; i < n; i++) begin
      vmem_stall_i = stall_mask[i];
      #1;
      if (vmem_we_o === 1'b1) begin
        cap_addr.push_back(vmem_addr_o);
        cap_data.push_back(vmem_wdata_o);
        cap_idx.push_back(i);
        $display("pixel cycle=%0d addr=%h data=%h", i, vmem_addr_o, vmem_wdata_o);
      end
      @(posedge clk_i); #1;
    end
    vmem_stall_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_ni = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; vmem_stall_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    checks++;
    if (vmem_we_o !== 1'b0 || vmem_addr_o !== 16'h0 || vmem_wdata_o !== 8'h0) begin
      errors++; $display("FAIL reset_vmem: got we=%b addr=%h data=%h expected 0", vmem_we_o, vmem_addr_o, vmem_wdata_o);
    end
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_size: got %h expected 00000000", d); end
  endtask

  task automatic test_basic_fill();
    logic [15:0] exp_a[6] = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_140A);
    bus_write(4'h4, 32'h0002_0003);
    bus_write(4'h8, 32'h1234_56A5);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0000_140A) begin errors++; $display("FAIL pos_read: got %h expected 0000140a", d); end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0002_0003) begin errors++; $display("FAIL size_read: got %h expected 00020003", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h0000_00A5) begin errors++; $display("FAIL color_read: got %h expected 000000a5", d); end
    bus_write(4'hC, 32'h1);
    capture(10, 32'h0);
    checks++;
    if (cap_addr.size() != 6) begin
      errors++; $display("FAIL basic_count: got %0d expected 6", cap_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap_addr[i] !== exp_a[i] || cap_data[i] !== 8'hA5 || cap_idx[i] != i) begin
          errors++;
          $display("FAIL basic_pix%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=a5 cyc=%0d",
                   i, cap_addr[i], cap_data[i], cap_idx[i], exp_a[i], i);
        end
      end
    end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL basic_status: got %h expected 00000002", d); end
    bus_write(4'hC, 32'h4);
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clr_done: got %h expected 00000000", d); end
  endtask

  task automatic test_clip();
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_EFEE);
    bus_write(4'h4, 32'h0005_0005);
    bus_write(4'hC, 32'h1);
    capture(6, 32'h0);
    checks++;
    if (cap_addr.size() != 2) begin
      errors++; $display("FAIL clip_count: got %0d expected 2", cap_addr.size());
    end else begin
      checks++;
      if (cap_addr[0] !== 16'hEFEE || cap_addr[1] !== 16'hEFEF) begin
        errors++; $display("FAIL clip_addr: got %h,%h expected efee,efef", cap_addr[0], cap_addr[1]);
      end
    end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL clip_status: got %h expected 00000002", d); end
    bus_write(4'hC, 32'h4);
  endtask

  task automatic test_empty();
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_140A);
    bus_write(4'h4, 32'h0002_0000);
    bus_write(4'hC, 32'h1);
    capture(4, 32'h0);
    checks++;
    if (cap_addr.size() != 0) begin errors++; $display("FAIL empty_w_count: got %0d expected 0", cap_addr.size()); end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL empty_w_status: got %h expected 00000002", d); end
    bus_write(4'hC, 32'h4);
    bus_write(4'h0, 32'h0000_14F0);
    bus_write(4'h4, 32'h0002_0003);
    bus_write(4'hC, 32'h1);
    capture(4, 32'h0);
    checks++;
    if (cap_addr.size() != 0) begin errors++; $display("FAIL empty_x_count: got %0d expected 0", cap_addr.size()); end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL empty_x_status: got %h expected 00000002", d); end
    bus_write(4'hC, 32'h4);
  endtask

  task automatic test_stall();
    int          exp_c[4] = '{0, 3, 4, 5};
    logic [15:0] exp_a[4] = '{16'h140A, 16'h140B, 16'h140C, 16'h140D};
    bus_write(4'h0, 32'h0000_140A);
    bus_write(4'h4, 32'h0001_0004);
    bus_write(4'hC, 32'h1);
    capture(8, 32'b0110);
    checks++;
    if (cap_addr.size() != 4) begin
      errors++; $display("FAIL stall_count: got %0d expected 4", cap_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_addr[i] !== exp_a[i] || cap_idx[i] != exp_c[i]) begin
          errors++;
          $display("FAIL stall_pix%0d: got addr=%h cyc=%0d expected addr=%h cyc=%0d",
                   i, cap_addr[i], cap_idx[i], exp_a[i], exp_c[i]);
        end
      end
    end
    bus_write(4'hC, 32'h4);
  endtask

  task automatic test_start_while_busy();
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_140A);
    bus_write(4'h4, 32'h0002_0003);
    bus_write(4'hC, 32'h1);
    capture(2, 32'h0);
    checks++;
    if (cap_addr.size() != 2 || cap_addr[0] !== 16'h140A) begin
      errors++; $display("FAIL busy_first: got %0d writes expected 2 starting 140a", cap_addr.size());
    end
    bus_write(4'hC, 32'h1);   // third pixel (140C) goes out during this write
    capture(6, 32'h0);
    checks++;
    if (cap_addr.size() != 3) begin
      errors++; $display("FAIL busy_rest_count: got %0d expected 3", cap_addr.size());
    end else begin
      checks++;
      if (cap_addr[0] !== 16'h150A || cap_addr[1] !== 16'h150B || cap_addr[2] !== 16'h150C) begin
        errors++; $display("FAIL busy_rest_addr: got %h,%h,%h expected 150a,150b,150c", cap_addr[0], cap_addr[1], cap_addr[2]);
      end
    end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL busy_status: got %h expected 00000002", d); end
    bus_write(4'hC, 32'h4);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int          n = 0;
    int          cyc = 0;
    bus_write(4'h0, 32'h0000_0000);
    bus_write(4'h4, 32'h00F0_00F0);
    bus_write(4'hC, 32'h1);
    while (n < 100 && cyc < 300) begin
      if (vmem_we_o === 1'b1) n++;
      if (n < 100) begin
        @(posedge clk_i); #1;
      end
      cyc++;
    end
    checks++;
    if (n != 100) begin errors++; $display("FAIL abort_timeout: got %0d writes expected 100", n); end
    $display("abort issued after %0d writes", n);
    bus_write(4'hC, 32'h2);
    capture(5, 32'h0);
    checks++;
    if (cap_addr.size() != 0) begin errors++; $display("FAIL abort_extra: got %0d writes expected 0", cap_addr.size()); end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL abort_status: got %h expected 00000000", d); end
  endtask

  task automatic test_start_abort();
    logic [31:0] d;
    bus_write(4'h4, 32'h0002_0003);
    bus_write(4'hC, 32'h3);
    capture(4, 32'h0);
    checks++;
    if (cap_addr.size() != 0) begin errors++; $display("FAIL start_abort_count: got %0d expected 0", cap_addr.size()); end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL start_abort_status: got %h expected 00000000", d); end
  endtask

  task automatic test_clr_set_wins();
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_140A);
    bus_write(4'h4, 32'h0001_0001);
    bus_write(4'hC, 32'h1);
    checks++;
    if (vmem_we_o !== 1'b1 || vmem_addr_o !== 16'h140A) begin
      errors++; $display("FAIL clrset_pix: got we=%b addr=%h expected we=1 addr=140a", vmem_we_o, vmem_addr_o);
    end
    bus_write(4'hC, 32'h4);   // lands on the completion edge
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL clrset_status: got %h expected 00000002", d); end
    bus_write(4'hC, 32'h4);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_140A);
    bus_write(4'h4, 32'h0001_0001);
    bus_write(4'hC, 32'h9);
    checks++;
    if (vmem_we_o !== 1'b1 || irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_during_write: got we=%b irq=%b expected we=1 irq=0", vmem_we_o, irq_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (irq_o !== IRQ_BUILD) begin errors++; $display("FAIL irq_rise: got %b expected %b", irq_o, IRQ_BUILD); end
    bus_read(4'hC, d);
    checks++;
    if (d !== (IRQ_BUILD ? 32'hA : 32'h2)) begin
      errors++; $display("FAIL irq_status: got %h expected %h", d, (IRQ_BUILD ? 32'hA : 32'h2));
    end
    bus_write(4'hC, 32'hC);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq_o); end
    bus_write(4'hC, 32'h0);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    bus_write(4'h0, 32'h0000_0000);
    bus_write(4'h4, 32'h00F0_00F0);
    bus_write(4'h8, 32'h0000_005A);
    bus_write(4'hC, 32'h1);
    capture(3, 32'h0);
    checks++;
    if (cap_addr.size() != 3 || cap_data[0] !== 8'h5A) begin
      errors++; $display("FAIL midrun_pre: got %0d writes expected 3 with data 5a", cap_addr.size());
    end
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    checks++;
    if (vmem_we_o !== 1'b0 || vmem_addr_o !== 16'h0) begin
      errors++; $display("FAIL midrun_we: got we=%b addr=%h expected we=0 addr=0000", vmem_we_o, vmem_addr_o);
    end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrun_pos: got %h expected 00000000", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrun_color: got %h expected 00000000", d); end
    capture(3, 32'h0);
    checks++;
    if (cap_addr.size() != 0) begin errors++; $display("FAIL midrun_post: got %0d writes expected 0", cap_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_clip();
    test_empty();
    test_stall();
    test_start_while_busy();
    test_abort();
    test_start_abort();
    test_clr_set_wins();
    test_irq();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_rect_fill.md
Name: vmem_rect_fill

Overview:
- Memory-mapped rectangle-fill engine that sits directly upstream of the video memory write port.
- The CPU programs position, size and colour over the data bus, then starts the engine.
- The engine writes one 8-bit pixel per cycle into vmem in raster order, replacing long CPU store loops for screen clears and box drawing.
- The top level muxes its vmem port with the CPU's direct vmem stores; CPU stores have priority and stall the engine.

Parameters:
- SCR_W, 240, visible width in pixels.
- SCR_H, 240, visible height in pixels.
- VADDR_W, 16, vmem address width; address = {y[7:0], x[7:0]}.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
- we_i  in  1  register write strobe (dbus_we qualified by the engine's address decode).
- addr_i  in  4  register byte offset; bits [3:2] select the register.
- wdata_i  in  32  register write data.
- rdata_o  out  32  registered read data.
- vmem_stall_i  in  1  high while the CPU owns the vmem port this cycle.
- vmem_we_o  out  1  pixel write strobe.
- vmem_addr_o  out  16  pixel address {y, x}.
- vmem_wdata_o  out  8  pixel colour.
- irq_o  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Registers (reset value 0 for all):
  - 0x0 POS: [7:0] x0, [15:8] y0.
  - 0x4 SIZE: [8:0] w, [24:16] h.
  - 0x8 COLOR: [7:0].
  - 0xC CTRL. Write: bit0 START, bit1 ABORT, bit2 CLR_DONE, bit3 IRQ_EN. Read: bit0 busy, bit1 done, bit3 irq_en.
- Read timing: rdata_o is registered with 1-cycle latency. It reflects addr_i from the previous cycle. Unused bits read 0.
- Register updates: POS, SIZE and COLOR are always writable. A write during an operation affects only the next operation, because the working copies are latched at start.
- FSM states: IDLE, RUN.
- IDLE -> RUN on a CTRL write with START=1 and ABORT=0.
  - At that edge, latch cx=x0, cy=y0, col=COLOR.
  - Clipped extents: ew = min(w, SCR_W-x0), eh = min(h, SCR_H-y0).
- Empty starts: if x0>=SCR_W, y0>=SCR_H, w==0 or h==0, stay in IDLE, set done, and issue no writes.
- RUN, each cycle with vmem_stall_i=0:
  - vmem_we_o=1, vmem_addr_o={cy,cx}, vmem_wdata_o=col.
  - Advance cx. At the row end (cx==x0+ew-1), wrap cx to x0 and increment cy.
  - After the last pixel (cy==y0+eh-1 and row end): go to IDLE and set done.
- RUN with vmem_stall_i=1: vmem_we_o=0 and counters hold. No pixel is lost or duplicated.
- Output timing: vmem outputs are combinational from state and counters. vmem_we_o is 0 in IDLE. Address and data are don't-care when we=0 but are driven to 0 in IDLE.
- Throughput: the first write is in the cycle after the START edge. An unstalled fill takes exactly ew*eh cycles.
- Boundary and conflict cases:
  - START while busy: ignored.
  - ABORT: RUN -> IDLE at the next edge with no further writes; done stays unchanged.
  - START and ABORT in the same write: ABORT wins and no operation starts.
  - CLR_DONE together with completion in the same cycle: done ends at 1 (set wins).
  - Synchronous reset mid-RUN: IDLE, all registers 0, vmem_we_o=0 from the next cycle.
- Arithmetic: compute with 9-bit sums so x0+ew never wraps; the maximum value is 240.

Optional Feature:
- Macro: VMEM_RECT_FILL_IRQ_EN.
- Defined: irq_o = done & irq_en, a level output cleared by CLR_DONE or by clearing IRQ_EN.
- Undefined: irq_o is tied to 0, the irq_en flop is removed, and CTRL bit3 reads 0.

Decomposition:
- Shared package holds:
  - register offsets (POS, SIZE, COLOR, CTRL);
  - CTRL bit indices;
  - SCR_W/SCR_H defaults;
  - the FSM state encoding.
- One sub-module, vmem_rect_walker: the x/y counter pair with clip limits, a step enable (RUN & ~stall), and last-pixel detect. Register file and FSM stay in the top.

Test Plan:
- Basic fill: POS=(10,20), SIZE=(3,2), COLOR=0xA5, START -> exactly 6 writes on consecutive cycles, addresses 0x140A,0x140B,0x140C,0x150A,0x150B,0x150C, data 0xA5; then busy=0, done=1.
- Clipping: POS=(238,239), SIZE=(5,5) -> 2 writes (0xEFEE, 0xEFEF), then done.
- Empty start: SIZE w=0 -> no vmem_we_o, done=1 on the next read. A separate case with x0=240 gives the same result.
- Stall: 4-pixel fill with vmem_stall_i high for cycles 2-3 -> 4 writes over 6 cycles with the same address sequence and no duplicates.
- Abort and restart: start a 240x240 fill, ABORT after 100 writes -> exactly 100 writes, busy=0, done=0. START while busy is ignored; START+ABORT together starts nothing.
- IRQ (macro defined): IRQ_EN=1, 1x1 fill -> irq_o rises 1 cycle after the single write, and falls after a CTRL write of CLR_DONE. With the macro undefined, irq_o stays 0 throughout.
